// File: rtl/renkon_sched.sv
// renkon_sched: job-level loop-nest scheduler sequencing weight load, convolution and write-out per pass
module renkon_sched #(
    parameter int CORE   = 8,
    parameter int LWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [LWIDTH-1:0] total_out,
    input  logic [LWIDTH-1:0] total_in,
    output logic              ack,
    output logic              ker_start,
    input  logic              ker_done,
    output logic              conv_start,
    input  logic              conv_done,
    output logic              out_start,
    input  logic              out_done,
    output logic              first_in,
    output logic              last_in,
    output logic [LWIDTH-1:0] out_base,
    output logic [LWIDTH-1:0] in_idx,
    output logic [LWIDTH-1:0] out_num
);
    typedef enum logic [2:0] {IDLE, WLOAD, WWAIT, CONV, CWAIT, OUT, OWAIT} state_t;
    localparam logic [LWIDTH:0] CORE_X = (LWIDTH + 1)'(CORE);
    state_t state;
    logic [LWIDTH-1:0] tot_out, tot_in;
    logic [LWIDTH:0] base_x, rem;
    logic busy, pass_last, tile_last;
    // Tile arithmetic is one bit wider so out_base+CORE never wraps.
    assign busy      = state != IDLE;
    assign base_x    = {1'b0, out_base};
    assign rem       = {1'b0, tot_out} - base_x;
    assign tile_last = base_x + CORE_X >= {1'b0, tot_out};
    assign pass_last = in_idx == tot_in - LWIDTH'(1);
    assign ack        = !busy;
    assign ker_start  = state == WLOAD;
    assign conv_start = state == CONV;
    assign out_start  = state == OUT;
    assign first_in   = busy && in_idx == '0;
    assign last_in    = busy && pass_last;
    assign out_num    = !busy ? '0 : rem > CORE_X ? LWIDTH'(CORE) : rem[LWIDTH-1:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tot_out  <= '0;
            tot_in   <= '0;
            out_base <= '0;
            in_idx   <= '0;
        end else begin
            case (state)
                IDLE: if (req && total_out != '0 && total_in != '0) begin
                    tot_out  <= total_out;
                    tot_in   <= total_in;
                    out_base <= '0;
                    in_idx   <= '0;
                    state    <= WLOAD;
                end
                WLOAD: state <= WWAIT;
                WWAIT: if (ker_done) state <= CONV;
                CONV:  state <= CWAIT;
                CWAIT: if (conv_done) begin
                    if (pass_last) state <= OUT;
                    else begin
                        in_idx <= in_idx + LWIDTH'(1);
                        state  <= WLOAD;
                    end
                end
                OUT: state <= OWAIT;
                OWAIT: if (out_done) begin
                    if (tile_last) state <= IDLE;
                    else begin
                        out_base <= out_base + LWIDTH'(CORE);
                        in_idx   <= '0;
                        state    <= WLOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_renkon_sched.sv
// tb_renkon_sched: scoreboard bench for renkon_sched; expected strobe events are queued at req time
module tb_renkon_sched;
    localparam int CORE = 8;
    localparam int LW   = 10;
    typedef struct packed {
        logic [1:0]    k;
        logic [LW-1:0] b;
        logic [LW-1:0] i;
        logic [LW-1:0] n;
        logic          f;
        logic          l;
    } ev_t;
    logic clk = 0, rst = 1, req = 0, conv_stray = 0;
    logic [LW-1:0] total_out = '0, total_in = '0;
    logic ack, ker_start, conv_start, out_start, first_in, last_in;
    logic ker_done, conv_done, out_done;
    logic [LW-1:0] out_base, in_idx, out_num;
    logic [2:0] dn = '0;
    int cdn[3], hl[3];
    ev_t sb[$];
    int checks = 0, errors = 0, cyc = 0, trig = 0, last_od = -100, n_conv = 0, ker_hold = 1;
    assign ker_done  = dn[0];
    assign conv_done = dn[1] | conv_stray;
    assign out_done  = dn[2];

    renkon_sched #(.CORE(CORE), .LWIDTH(LW)) dut (
        .clk(clk), .rst(rst), .req(req), .total_out(total_out), .total_in(total_in),
        .ack(ack), .ker_start(ker_start), .ker_done(ker_done), .conv_start(conv_start),
        .conv_done(conv_done), .out_start(out_start), .out_done(out_done),
        .first_in(first_in), .last_in(last_in), .out_base(out_base), .in_idx(in_idx),
        .out_num(out_num)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk(int k, int b, int i, int n, bit f, bit l);
        ev_t e;
        e.k = 2'(k); e.b = LW'(b); e.i = LW'(i); e.n = LW'(n); e.f = f; e.l = l;
        return e;
    endfunction

    function automatic void push_job(int to, int ti, int lim);
        int passes = 0;
        for (int ob = 0; ob < to; ob += CORE) begin
            int n = (to - ob < CORE) ? to - ob : CORE;
            for (int i = 0; i < ti; i++) begin
                sb.push_back(mk(0, ob, i, n, i == 0, i == ti - 1));
                sb.push_back(mk(1, ob, i, n, i == 0, i == ti - 1));
                passes++;
                if (lim != 0 && passes == lim) return;
            end
            sb.push_back(mk(2, ob, ti - 1, n, ti == 1, 1'b1));
        end
    endfunction

    // done responders: each done rises 2 cycles after its strobe and stays high for hold cycles
    initial forever begin
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            logic s;
            s = j == 0 ? ker_start : j == 1 ? conv_start : out_start;
            if (rst) begin
                cdn[j] = 0;
                hl[j]  = 0;
            end else begin
                if (hl[j] > 0) hl[j]--;
                if (cdn[j] > 0) begin
                    cdn[j]--;
                    if (cdn[j] == 0) begin
                        hl[j] = j == 0 ? ker_hold : 1;
                        trig  = cyc;
                        if (j == 2) last_od = cyc;
                    end
                end
                if (s) cdn[j] = 2;
            end
            dn[j] = hl[j] > 0;
        end
    end

    // monitor: every strobe pops one expected event and must follow its trigger by one cycle
    initial forever begin
        @(negedge clk);
        if (!rst && (ker_start || conv_start || out_start)) begin
            ev_t o;
            o.k = ker_start ? 2'd0 : conv_start ? 2'd1 : 2'd2;
            o.b = out_base; o.i = in_idx; o.n = out_num; o.f = first_in; o.l = last_in;
            chk("strobe_onehot", 64'($countones({ker_start, conv_start, out_start})), 1);
            chk("strobe_timing", cyc, trig + 1);
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) chk("event", o, sb.pop_front());
            if (conv_start) n_conv++;
        end
    end

    task automatic issue_req(input int to, input int ti, input int lim);
        @(negedge clk);
        req = 1; total_out = LW'(to); total_in = LW'(ti); trig = cyc;
        if (to != 0 && ti != 0) push_job(to, ti, lim);
        @(negedge clk);
        req = 0;
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (ack) break;
        end
        chk({nm, "_ack"}, ack, 1);
        chk({nm, "_ack_lat"}, cyc, last_od + 1);
        chk({nm, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic chk_rst_vals(input string nm);
        chk(nm, {ack, ker_start, conv_start, out_start, first_in, last_in, out_base, in_idx, out_num},
            {1'b1, 35'd0});
    endtask

    initial begin
        int nk, n0;
        repeat (3) @(negedge clk);
        chk_rst_vals("reset_state");
        rst = 0;
        @(negedge clk);
        chk_rst_vals("idle_after_reset");
        // 20/3 job with a busy req for 64 maps that must be ignored
        issue_req(20, 3, 0);
        repeat (30) @(negedge clk);
        chk("busy_mid_job", ack, 0);
        req = 1; total_out = 64; total_in = 7;
        @(negedge clk);
        req = 0;
        wait_idle("job20x3");
        // zero-sized jobs are accepted as no-ops
        issue_req(0, 5, 0);
        repeat (20) begin @(negedge clk); chk("null_out_ack", ack, 1); end
        issue_req(5, 0, 0);
        repeat (20) begin @(negedge clk); chk("null_in_ack", ack, 1); end
        issue_req(5, 1, 0);
        wait_idle("job5x1");
        // held ker_done and a stray conv_done in a WLOAD cycle
        ker_hold = 5;
        issue_req(16, 2, 0);
        nk = 1;
        for (int k = 0; k < 200 && nk < 2; k++) begin
            @(negedge clk);
            if (ker_start) nk++;
        end
        chk("stray_wload_found", nk, 2);
        conv_stray = 1;
        @(negedge clk);
        conv_stray = 0;
        wait_idle("job16x2_hold");
        ker_hold = 1;
        // reset during CWAIT of the 4th pass
        n0 = n_conv;
        issue_req(20, 3, 4);
        for (int k = 0; k < 500 && n_conv != n0 + 4; k++) @(negedge clk);
        chk("pass4_reached", n_conv, n0 + 4);
        @(posedge clk);
        #1 chk("pre_rst_base", out_base, 8);
        #1 rst = 1;
        #1 chk_rst_vals("async_reset");
        chk("rst_sb_empty", sb.size(), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        issue_req(8, 2, 0);
        wait_idle("job8x2_after_rst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (errors %0d)", errors);
        $fatal(1, "watchdog expired");
    end
endmodule
